uart_tx_frame_counter: RTL and testbench
========================================

Name: uart_tx_frame_counter

Overview:
Parametrised successor to the transmitter bit counter. It tracks the position within a complete UART transmit frame: start bit, DATA_BITS data bits, optional parity bit, and 1 or 2 stop bits. Baud ticks can be oversampled. It drives the frame phase, the bit position, and bit/frame strobes to the transmitter controller and shift register. It sits between the baud generator and the TX controller, and it replaces the fixed 4-bit counter.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 1, clk_baud ticks per bit period; legal range 1..16; 1 means one tick per bit.
POS_W, 4, width of bit_counter; must satisfy 2**POS_W > DATA_BITS+3.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_baud  in  1  baud tick enable, one clk cycle wide
load  in  1  start-frame request, one clk cycle wide
parity_en  in  1  frame includes a parity bit; sampled on accepted load
stop2  in  1  frame uses 2 stop bits (else 1); sampled on accepted load
busy  out  1  frame in progress
phase  out  3  IDLE/START/DATA/PARITY/STOP encoding (uart_pkg)
bit_counter  out  POS_W  bit position in frame: 0 = start, 1..DATA_BITS = data, then parity, then stop(s)
data_idx  out  4  current data bit index, 0..DATA_BITS-1; 0 outside DATA
bit_strobe  out  1  last tick of the current bit (combinational)
frame_done  out  1  one-cycle registered pulse after the final stop bit ends
ovr_err  out  1  one-cycle registered pulse when load arrives while busy and is not accepted

Behaviour:
- Reset (asynchronous, active-high):
  - phase=IDLE; busy=0; bit_counter=0; data_idx=0.
  - Internal tick counter=0; frame_done=0; ovr_err=0; latched modes=0.
  - Recovery takes effect on the first clk edge after deassertion.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued.
- Tick counter (width clog2(OVERSAMPLE), min 1):
  - Increments on clk_baud while not IDLE.
  - Clears at bit end.
- bit_strobe = clk_baud & (tick==OVERSAMPLE-1) & (phase!=IDLE). Never asserted in IDLE.
- Load acceptance:
  - Accepted in IDLE. Next cycle: phase=START, busy=1, counters=0, parity_en/stop2 latched.
  - A clk_baud in the same cycle as load is ignored; counting begins on the following tick.
- Transitions, taken on bit_strobe only:
  - START -> DATA.
  - DATA with data_idx<DATA_BITS-1 -> DATA, data_idx+1.
  - Last DATA -> PARITY if latched parity_en, else STOP.
  - PARITY -> STOP.
  - STOP -> STOP (second stop) if latched stop2 and first stop.
  - Final STOP -> IDLE.
- bit_counter increments by 1 on every bit_strobe except the final one. It resets to 0 on return to IDLE or on an accepted load.
- frame_done pulses in the cycle after the final STOP strobe, coincident with the first IDLE cycle.
- Frame length in bit periods = 1 + DATA_BITS + parity_en + 1 + stop2. With OVERSAMPLE=1 and continuous ticks, this is also the number of clk_baud ticks.
- Back-to-back frames:
  - load in the same cycle as the final STOP bit_strobe is accepted.
  - Next cycle: phase=START, counters=0, new modes latched, frame_done=1, ovr_err=0. busy stays 1 with no gap.
- load while busy and not on the final strobe is ignored: ovr_err pulses next cycle and frame state is unaffected.
- Changes to parity_en/stop2 mid-frame have no effect.
- Ticks with no bit_strobe (OVERSAMPLE>1) change only the tick counter.

Decomposition:
- uart_pkg holds the phase encoding constants (PH_IDLE=0, PH_START=1, PH_DATA=2, PH_PARITY=3, PH_STOP=4) and a clog2 function. These are shared with the RX frame counter and the TX controller.
- One sub-module is natural: uart_tick_divider. It holds the OVERSAMPLE tick counter and produces bit_strobe, with enable and clear inputs.
- The frame FSM and position counters stay in the top module.

Test Plan:
- Reset mid-frame: DATA_BITS=8, OVERSAMPLE=1, load, 4 ticks, assert reset -> phase=IDLE, bit_counter=0, busy=0 asynchronously; no frame_done.
- 8N1 frame: load, then 10 ticks spaced 3 clk apart -> bit_counter 0..9, data_idx 0..7 during DATA, frame_done exactly once after tick 10, busy=0.
- 8E2 frame: parity_en=1, stop2=1, load -> 12 ticks to frame_done; phase sequence START, DATA×8, PARITY, STOP×2.
- OVERSAMPLE=16, 7N1 (DATA_BITS=7): load -> bit_strobe every 16th tick; frame_done after 144 ticks.
- Back-to-back: load on the final-stop strobe cycle -> next cycle phase=START, frame_done=1, ovr_err=0, busy never drops.
- Overrun and mode stability: load during DATA -> ovr_err one pulse, bit_counter unchanged; toggling stop2 mid-frame leaves frame length unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame phase encoding and an elaboration-time clog2.
// The TX/RX frame counters and the TX controller all use these.
package uart_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_START  = 3'd1,
    PH_DATA   = 3'd2,
    PH_PARITY = 3'd3,
    PH_STOP   = 3'd4
  } phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_frame_counter_if.sv
// Bus between the TX frame counter (slave) and the TX controller / baud side (master).
// The counter is the slave because it consumes the tick/load requests and reports frame position back.
interface uart_tx_frame_counter_if #(
  parameter int POS_W = 4
);

  logic             clk_baud;
  logic             load;
  logic             parity_en;
  logic             stop2;
  logic             busy;
  logic [2:0]       phase;
  logic [POS_W-1:0] bit_counter;
  logic [3:0]       data_idx;
  logic             bit_strobe;
  logic             frame_done;
  logic             ovr_err;

  modport master (
    output clk_baud, load, parity_en, stop2,
    input  busy, phase, bit_counter, data_idx, bit_strobe, frame_done, ovr_err
  );

  modport slave (
    input  clk_baud, load, parity_en, stop2,
    output busy, phase, bit_counter, data_idx, bit_strobe, frame_done, ovr_err
  );

endinterface

// File: rtl/uart_tick_divider.sv
// Oversample tick counter: counts clk_baud ticks within one bit period and flags the last one.
// The strobe is combinational so the frame FSM can advance in the same cycle as the final tick.
module uart_tick_divider
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic en_i,
  input  logic clr_i,
  output logic bitStrobe_o
);

  localparam int TICK_W = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] tickCnt_q;
  logic [TICK_W-1:0] tickCnt_d;
  logic              lastTick;

  assign lastTick    = (tickCnt_q == LAST_TICK);
  assign bitStrobe_o = tick_i & en_i & lastTick;

  always_comb begin
    tickCnt_d = tickCnt_q;
    if (clr_i) begin
      tickCnt_d = '0;
    end else if (tick_i && en_i) begin
      tickCnt_d = lastTick ? '0 : tickCnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_counter.sv
// Tracks position within a UART TX frame (start, data, optional parity, 1/2 stop bits)
// and emits bit/frame strobes plus an overrun pulse for loads that arrive mid-frame.
module uart_tx_frame_counter
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 1,
  parameter int POS_W      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_frame_counter_if.slave   bus
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);

  phase_e           phase_q,      phase_d;
  logic [POS_W-1:0] bitCounter_q, bitCounter_d;
  logic [3:0]       dataIdx_q,    dataIdx_d;
  logic             secondStop_q, secondStop_d;
  logic             parityEn_q,   parityEn_d;
  logic             stop2_q,      stop2_d;
  logic             frameDone_q,  frameDone_d;
  logic             ovrErr_q,     ovrErr_d;

  logic active;
  logic bitStrobe;
  logic lastStrobe;
  logic loadAccept;

  assign active     = (phase_q != PH_IDLE);
  assign lastStrobe = bitStrobe && (phase_q == PH_STOP) && (!stop2_q || secondStop_q);
  assign loadAccept = bus.load && (!active || lastStrobe);

  uart_tick_divider #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_divider (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (bus.clk_baud),
    .en_i        (active),
    .clr_i       (loadAccept),
    .bitStrobe_o (bitStrobe)
  );

  // Bit advance first; an accepted load then overrides the frame state, which lets
  // a load on the final stop strobe start the next frame while still reporting frame_done.
  always_comb begin
    phase_d      = phase_q;
    bitCounter_d = bitCounter_q;
    dataIdx_d    = dataIdx_q;
    secondStop_d = secondStop_q;
    parityEn_d   = parityEn_q;
    stop2_d      = stop2_q;
    frameDone_d  = 1'b0;
    ovrErr_d     = 1'b0;

    if (bitStrobe) begin
      bitCounter_d = bitCounter_q + POS_W'(1);
      case (phase_q)
        PH_START: begin
          phase_d   = PH_DATA;
          dataIdx_d = 4'd0;
        end
        PH_DATA: begin
          if (dataIdx_q == LAST_DATA) begin
            dataIdx_d = 4'd0;
            phase_d   = parityEn_q ? PH_PARITY : PH_STOP;
          end else begin
            dataIdx_d = dataIdx_q + 4'd1;
          end
        end
        PH_PARITY: begin
          phase_d = PH_STOP;
        end
        PH_STOP: begin
          if (stop2_q && !secondStop_q) begin
            secondStop_d = 1'b1;
          end else begin
            phase_d      = PH_IDLE;
            bitCounter_d = '0;
            secondStop_d = 1'b0;
            frameDone_d  = 1'b1;
          end
        end
        default: begin
          phase_d = PH_IDLE;
        end
      endcase
    end

    if (bus.load) begin
      if (loadAccept) begin
        phase_d      = PH_START;
        bitCounter_d = '0;
        dataIdx_d    = 4'd0;
        secondStop_d = 1'b0;
        parityEn_d   = bus.parity_en;
        stop2_d      = bus.stop2;
      end else begin
        ovrErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_IDLE;
      bitCounter_q <= '0;
      dataIdx_q    <= 4'd0;
      secondStop_q <= 1'b0;
      parityEn_q   <= 1'b0;
      stop2_q      <= 1'b0;
      frameDone_q  <= 1'b0;
      ovrErr_q     <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      bitCounter_q <= bitCounter_d;
      dataIdx_q    <= dataIdx_d;
      secondStop_q <= secondStop_d;
      parityEn_q   <= parityEn_d;
      stop2_q      <= stop2_d;
      frameDone_q  <= frameDone_d;
      ovrErr_q     <= ovrErr_d;
    end
  end

  assign bus.busy        = active;
  assign bus.phase       = phase_q;
  assign bus.bit_counter = bitCounter_q;
  assign bus.data_idx    = dataIdx_q;
  assign bus.bit_strobe  = bitStrobe;
  assign bus.frame_done  = frameDone_q;
  assign bus.ovr_err     = ovrErr_q;

endmodule

// File: tb/tb_uart_tx_frame_counter.sv
// Testbench for uart_tx_frame_counter: an 8-bit/1x instance and a 7-bit/16x instance,
// randomized tick spacing and modes, checked against a frame-position model.
module tb_uart_tx_frame_counter;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  uart_tx_frame_counter_if #(.POS_W(4)) ifA ();
  uart_tx_frame_counter_if #(.POS_W(4)) ifB ();

  uart_tx_frame_counter #(.DATA_BITS(8), .OVERSAMPLE(1), .POS_W(4)) dutA (
    .clk(clk), .reset(reset), .bus(ifA)
  );

  uart_tx_frame_counter #(.DATA_BITS(7), .OVERSAMPLE(16), .POS_W(4)) dutB (
    .clk(clk), .reset(reset), .bus(ifB)
  );

  always #5 clk = ~clk;

  // Frame model: b = number of completed bit periods since the load.
  function automatic logic [2:0] modelPhase(input int b, input int db, input bit p, input bit s2);
    int len;
    len = 2 + db + int'(p) + int'(s2);
    if (b >= len) return PH_IDLE;
    if (b == 0) return PH_START;
    if (b <= db) return PH_DATA;
    if (p && b == db + 1) return PH_PARITY;
    return PH_STOP;
  endfunction

  function automatic logic [3:0] modelIdx(input int b, input int db);
    return (b >= 1 && b <= db) ? 4'(b - 1) : 4'd0;
  endfunction

  function automatic logic [3:0] modelPos(input int b, input int len);
    return (b >= len) ? 4'd0 : 4'(b);
  endfunction

  task automatic tickA(input bit withLoad, input bit p, input bit s2);
    @(negedge clk);
    ifA.clk_baud = 1'b1;
    if (withLoad) begin
      ifA.load = 1'b1; ifA.parity_en = p; ifA.stop2 = s2;
    end
    @(negedge clk);
    ifA.clk_baud = 1'b0;
    ifA.load     = 1'b0;
  endtask

  task automatic gapA(input int maxGap);
    int n;
    n = $urandom_range(0, maxGap);
    repeat (n) begin
      @(negedge clk);
      ifA.parity_en = 1'($urandom);
      ifA.stop2     = 1'($urandom);
    end
  endtask

  task automatic loadA(input bit p, input bit s2);
    @(negedge clk);
    ifA.load = 1'b1; ifA.parity_en = p; ifA.stop2 = s2;
    ifA.clk_baud = 1'($urandom);
    @(negedge clk);
    ifA.load = 1'b0; ifA.clk_baud = 1'b0;
  endtask

  task automatic loadB(input bit p, input bit s2);
    @(negedge clk);
    ifB.load = 1'b1; ifB.parity_en = p; ifB.stop2 = s2;
    ifB.clk_baud = 1'($urandom);
    @(negedge clk);
    ifB.load = 1'b0; ifB.clk_baud = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifA.clk_baud = 0; ifA.load = 0; ifA.parity_en = 0; ifA.stop2 = 0;
    ifB.clk_baud = 0; ifB.load = 0; ifB.parity_en = 0; ifB.stop2 = 0;
    #3;
    checks++; if (ifA.phase !== PH_IDLE) begin fails++; $display("[TB] FAIL reset phase: got %0d expected 0", ifA.phase); end
    checks++; if (ifA.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b expected 0", ifA.busy); end
    checks++; if (ifA.bit_counter !== 4'd0) begin fails++; $display("[TB] FAIL reset bit_counter: got %0d expected 0", ifA.bit_counter); end
    checks++; if (ifA.data_idx !== 4'd0) begin fails++; $display("[TB] FAIL reset data_idx: got %0d expected 0", ifA.data_idx); end
    checks++; if (ifA.frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset frame_done: got %b expected 0", ifA.frame_done); end
    checks++; if (ifA.ovr_err !== 1'b0) begin fails++; $display("[TB] FAIL reset ovr_err: got %b expected 0", ifA.ovr_err); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ifA.clk_baud = 1'b1; ifB.clk_baud = 1'b1;
    #1;
    checks++; if (ifA.bit_strobe !== 1'b0) begin fails++; $display("[TB] FAIL idle bit_strobe A: got %b expected 0", ifA.bit_strobe); end
    checks++; if (ifB.bit_strobe !== 1'b0) begin fails++; $display("[TB] FAIL idle bit_strobe B: got %b expected 0", ifB.bit_strobe); end
    @(negedge clk);
    ifA.clk_baud = 1'b0; ifB.clk_baud = 1'b0;
    checks++; if (ifA.phase !== PH_IDLE) begin fails++; $display("[TB] FAIL idle tick phase A: got %0d expected 0", ifA.phase); end
    checks++; if (ifB.busy !== 1'b0) begin fails++; $display("[TB] FAIL idle tick busy B: got %b expected 0", ifB.busy); end
  endtask

  task automatic test_reset_mid_frame();
    loadA(1'b0, 1'b0);
    repeat (4) tickA(1'b0, 1'b0, 1'b0);
    checks++; if (ifA.bit_counter !== 4'd4) begin fails++; $display("[TB] FAIL pre-reset bit_counter: got %0d expected 4", ifA.bit_counter); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (ifA.phase !== PH_IDLE) begin fails++; $display("[TB] FAIL async reset phase: got %0d expected 0", ifA.phase); end
    checks++; if (ifA.bit_counter !== 4'd0) begin fails++; $display("[TB] FAIL async reset bit_counter: got %0d expected 0", ifA.bit_counter); end
    checks++; if (ifA.busy !== 1'b0) begin fails++; $display("[TB] FAIL async reset busy: got %b expected 0", ifA.busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tickA(1'b0, 1'b0, 1'b0);
      checks++; if (ifA.frame_done !== 1'b0 || ifA.phase !== PH_IDLE) begin
        fails++; $display("[TB] FAIL post-reset idle %0d: got done=%b phase=%0d expected done=0 phase=0", i, ifA.frame_done, ifA.phase);
      end
    end
  endtask

  task automatic test_frames();
    bit p, s2;
    int len;
    for (int f = 0; f < 8; f++) begin
      p  = (f == 0) ? 1'b0 : (f == 1) ? 1'b1 : 1'($urandom);
      s2 = (f == 0) ? 1'b0 : (f == 1) ? 1'b1 : 1'($urandom);
      len = 2 + 8 + int'(p) + int'(s2);
      loadA(p, s2);
      checks++; if (ifA.phase !== PH_START || ifA.busy !== 1'b1 || ifA.bit_counter !== 4'd0 || ifA.ovr_err !== 1'b0) begin
        fails++; $display("[TB] FAIL frame%0d load: got phase=%0d busy=%b pos=%0d ovr=%b expected 1 1 0 0", f, ifA.phase, ifA.busy, ifA.bit_counter, ifA.ovr_err);
      end
      for (int b = 1; b <= len; b++) begin
        gapA(2);
        tickA(1'b0, 1'b0, 1'b0);
        checks++; if (ifA.phase !== modelPhase(b, 8, p, s2)) begin
          fails++; $display("[TB] FAIL frame%0d phase bit %0d: got %0d expected %0d", f, b, ifA.phase, modelPhase(b, 8, p, s2));
        end
        checks++; if (ifA.bit_counter !== modelPos(b, len) || ifA.data_idx !== modelIdx(b, 8)) begin
          fails++; $display("[TB] FAIL frame%0d position bit %0d: got pos=%0d idx=%0d expected pos=%0d idx=%0d", f, b, ifA.bit_counter, ifA.data_idx, modelPos(b, len), modelIdx(b, 8));
        end
        checks++; if (ifA.frame_done !== (b == len) || ifA.busy !== (b != len)) begin
          fails++; $display("[TB] FAIL frame%0d done/busy bit %0d: got done=%b busy=%b expected done=%b busy=%b", f, b, ifA.frame_done, ifA.busy, b == len, b != len);
        end
      end
      @(negedge clk);
      checks++; if (ifA.frame_done !== 1'b0) begin fails++; $display("[TB] FAIL frame%0d done pulse width: got %b expected 0", f, ifA.frame_done); end
    end
  endtask

  task automatic test_oversample();
    bit p, s2;
    int len;
    int b;
    for (int f = 0; f < 3; f++) begin
      p  = (f == 0) ? 1'b0 : 1'($urandom);
      s2 = (f == 0) ? 1'b0 : 1'($urandom);
      len = 2 + 7 + int'(p) + int'(s2);
      loadB(p, s2);
      for (int n = 1; n <= len * 16; n++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        ifB.clk_baud = 1'b1;
        #1;
        checks++; if (ifB.bit_strobe !== (n % 16 == 0)) begin
          fails++; $display("[TB] FAIL os16 frame%0d strobe tick %0d: got %b expected %b", f, n, ifB.bit_strobe, n % 16 == 0);
        end
        @(negedge clk);
        ifB.clk_baud = 1'b0;
        b = n / 16;
        checks++; if (ifB.phase !== modelPhase(b, 7, p, s2) || ifB.bit_counter !== modelPos(b, len) || ifB.data_idx !== modelIdx(b, 7)) begin
          fails++; $display("[TB] FAIL os16 frame%0d state tick %0d: got phase=%0d pos=%0d idx=%0d expected %0d %0d %0d", f, n, ifB.phase, ifB.bit_counter, ifB.data_idx, modelPhase(b, 7, p, s2), modelPos(b, len), modelIdx(b, 7));
        end
        checks++; if (ifB.frame_done !== (n == len * 16)) begin
          fails++; $display("[TB] FAIL os16 frame%0d done tick %0d: got %b expected %b", f, n, ifB.frame_done, n == len * 16);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit p1, s21, p2, s22;
    int len1, len2;
    p1 = 1'($urandom); s21 = 1'($urandom); p2 = 1'($urandom); s22 = 1'($urandom);
    len1 = 10 + int'(p1) + int'(s21);
    len2 = 10 + int'(p2) + int'(s22);
    loadA(p1, s21);
    for (int b = 1; b < len1; b++) begin
      tickA(1'b0, 1'b0, 1'b0);
      checks++; if (ifA.busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b first busy bit %0d: got %b expected 1", b, ifA.busy); end
    end
    tickA(1'b1, p2, s22);
    checks++; if (ifA.phase !== PH_START || ifA.frame_done !== 1'b1 || ifA.ovr_err !== 1'b0 || ifA.busy !== 1'b1 || ifA.bit_counter !== 4'd0) begin
      fails++; $display("[TB] FAIL b2b restart: got phase=%0d done=%b ovr=%b busy=%b pos=%0d expected 1 1 0 1 0", ifA.phase, ifA.frame_done, ifA.ovr_err, ifA.busy, ifA.bit_counter);
    end
    for (int b = 1; b <= len2; b++) begin
      tickA(1'b0, 1'b0, 1'b0);
      checks++; if (ifA.phase !== modelPhase(b, 8, p2, s22) || ifA.busy !== (b != len2) || ifA.frame_done !== (b == len2)) begin
        fails++; $display("[TB] FAIL b2b second bit %0d: got phase=%0d busy=%b done=%b expected %0d %b %b", b, ifA.phase, ifA.busy, ifA.frame_done, modelPhase(b, 8, p2, s22), b != len2, b == len2);
      end
    end
  endtask

  task automatic test_overrun();
    loadA(1'b0, 1'b0);
    repeat (3) tickA(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ifA.load = 1'b1; ifA.parity_en = 1'b1; ifA.stop2 = 1'b1;
    @(negedge clk);
    ifA.load = 1'b0;
    checks++; if (ifA.ovr_err !== 1'b1 || ifA.bit_counter !== 4'd3 || ifA.phase !== PH_DATA || ifA.data_idx !== 4'd2) begin
      fails++; $display("[TB] FAIL overrun pulse: got ovr=%b pos=%0d phase=%0d idx=%0d expected 1 3 2 2", ifA.ovr_err, ifA.bit_counter, ifA.phase, ifA.data_idx);
    end
    @(negedge clk);
    checks++; if (ifA.ovr_err !== 1'b0) begin fails++; $display("[TB] FAIL overrun width: got %b expected 0", ifA.ovr_err); end
    tickA(1'b0, 1'b0, 1'b0);
    tickA(1'b1, 1'b1, 1'b1);
    checks++; if (ifA.ovr_err !== 1'b1 || ifA.bit_counter !== 4'd5) begin
      fails++; $display("[TB] FAIL overrun on strobe: got ovr=%b pos=%0d expected 1 5", ifA.ovr_err, ifA.bit_counter);
    end
    for (int b = 6; b <= 10; b++) begin
      tickA(1'b0, 1'b0, 1'b0);
      checks++; if (ifA.phase !== modelPhase(b, 8, 1'b0, 1'b0) || ifA.frame_done !== (b == 10)) begin
        fails++; $display("[TB] FAIL overrun frame bit %0d: got phase=%0d done=%b expected %0d %b", b, ifA.phase, ifA.frame_done, modelPhase(b, 8, 1'b0, 1'b0), b == 10);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_frames();
    test_oversample();
    test_back_to_back();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
